// File: rtl/post_addsub_simd.sv
// SIMD post-adder/subtractor with optional input register, valid pipeline and P feedback.
// Build option: define POST_ADD_SAT_EN to clamp overflowing lanes to signed max/min.
module post_addsub_simd #(
    parameter int WIDTH  = 48,
    parameter int LANES  = 1,
    parameter int REG_IN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x_a,
    input  logic [WIDTH-1:0] x_b,
    input  logic [WIDTH-1:0] x_c,
    input  logic [1:0]       x_sel,
    input  logic [WIDTH-1:0] z_a,
    input  logic [WIDTH-1:0] z_b,
    input  logic [1:0]       z_sel,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] p,
    output logic [LANES-1:0] cout,
    output logic [LANES-1:0] ovf,
    output logic             out_valid
);
    localparam int LW = WIDTH / LANES;

    // An operand is accepted on a rising edge where in_valid = 1 and ce = 1; there is
    // no backpressure. out_valid marks the edge that loaded p/cout/ovf and holds while ce = 0.

    logic [WIDTH-1:0] x_mux, z_mux;
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (x_sel)
            2'b01:   x_mux = x_a;
            2'b10:   x_mux = x_b;
            2'b11:   x_mux = x_c;
            default: x_mux = '0;
        endcase
        // z_sel = 11 selects p, which is read only at stage 2.
        case (z_sel)
            2'b01:   z_mux = z_a;
            2'b10:   z_mux = z_b;
            default: z_mux = '0;
        endcase
    end

    logic [WIDTH-1:0] x2, z2;
    logic [1:0]       zsel2;
    logic             sub2, cin2, v2;

    generate
        if (REG_IN != 0) begin : g_reg_in
            logic [WIDTH-1:0] x1_q, x1_d, z1_q, z1_d;
            logic [1:0]       zsel1_q, zsel1_d;
            logic             sub1_q, sub1_d, cin1_q, cin1_d, v1_q, v1_d;

            always_comb begin
                x1_d    = x1_q;
                z1_d    = z1_q;
                zsel1_d = zsel1_q;
                sub1_d  = sub1_q;
                cin1_d  = cin1_q;
                v1_d    = v1_q;
                if (ce) begin
                    x1_d    = x_mux;
                    z1_d    = z_mux;
                    zsel1_d = z_sel;
                    sub1_d  = sub;
                    cin1_d  = cin;
                    v1_d    = in_valid;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x1_q    <= '0;
                    z1_q    <= '0;
                    zsel1_q <= '0;
                    sub1_q  <= 1'b0;
                    cin1_q  <= 1'b0;
                    v1_q    <= 1'b0;
                end else begin
                    x1_q    <= x1_d;
                    z1_q    <= z1_d;
                    zsel1_q <= zsel1_d;
                    sub1_q  <= sub1_d;
                    cin1_q  <= cin1_d;
                    v1_q    <= v1_d;
                end
            end

            assign x2    = x1_q;
            assign z2    = z1_q;
            assign zsel2 = zsel1_q;
            assign sub2  = sub1_q;
            assign cin2  = cin1_q;
            assign v2    = v1_q;
        end else begin : g_no_reg
            assign x2    = x_mux;
            assign z2    = z_mux;
            assign zsel2 = z_sel;
            assign sub2  = sub;
            assign cin2  = cin;
            assign v2    = in_valid;
        end
    endgenerate

    logic [WIDTH-1:0] p_q, p_d, z_op, p_res;
    logic [LANES-1:0] cout_q, cout_d, ovf_q, ovf_d, cout_res, ovf_res;
    logic [LW-1:0]    xl, zl, lane_p;
    logic [LW:0]      r, c_ext;
    logic             lane_ovf;

    always_comb begin
        z_op     = (zsel2 == 2'b11) ? p_q : z2;
        p_res    = '0;
        cout_res = '0;
        ovf_res  = '0;
        xl       = '0;
        zl       = '0;
        r        = '0;
        c_ext    = '0;
        lane_p   = '0;
        lane_ovf = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            xl    = x2[i*LW +: LW];
            zl    = z_op[i*LW +: LW];
            c_ext = {{LW{1'b0}}, (i == 0) && cin2};
            // Bit LW of the widened result is the carry for add and the borrow for sub.
            if (sub2) begin
                r        = {1'b0, zl} - {1'b0, xl} - c_ext;
                lane_ovf = (zl[LW-1] != xl[LW-1]) && (r[LW-1] != zl[LW-1]);
            end else begin
                r        = {1'b0, zl} + {1'b0, xl} + c_ext;
                lane_ovf = (zl[LW-1] == xl[LW-1]) && (r[LW-1] != zl[LW-1]);
            end
            lane_p = r[LW-1:0];
`ifdef POST_ADD_SAT_EN
            // On overflow the true result carries the sign of Z.
            if (lane_ovf) begin
                lane_p = zl[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
            end
`endif
            p_res[i*LW +: LW] = lane_p;
            cout_res[i]       = r[LW];
            ovf_res[i]        = lane_ovf;
        end
    end

    logic out_valid_q, out_valid_d;
    always_comb begin
        p_d         = p_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = v2;
            if (v2) begin
                p_d    = p_res;
                cout_d = cout_res;
                ovf_d  = ovf_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            cout_q      <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
endmodule

// File: doc/post_addsub_simd.md
# post_addsub_simd

Parametrised successor to the DSP post-adder/subtractor stage. Adds the following to the original X/Z-mux adder:
- An input pipeline stage.
- A valid pipeline.
- P-register feedback for accumulation.
- SIMD lane splitting, with per-lane carry-out and signed-overflow flags.

It sits after the multiplier/pre-adder path and drives the slice P output.

## Interface
- WIDTH, 48, total datapath width; must be divisible by LANES
- LANES, 1, number of independent SIMD lanes (1, 2 or 4); lane width LW = WIDTH/LANES
- REG_IN, 1, 1 = operand/control input register stage present, 0 = bypassed
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable for every register in the block
- in_valid  in  1  operand set on inputs is valid this cycle
- x_a, x_b, x_c  in  WIDTH  X-mux sources
- x_sel  in  2  X mux: 00 = 0, 01 = x_a, 10 = x_b, 11 = x_c
- z_a, z_b  in  WIDTH  Z-mux sources
- z_sel  in  2  Z mux: 00 = 0, 01 = z_a, 10 = z_b, 11 = current p (accumulate)
- sub  in  1  0 = Z + X + cin, 1 = Z − (X + cin)
- cin  in  1  carry-in, applied to lane 0 only
- p  out  WIDTH  result register
- cout  out  LANES  per-lane carry-out (borrow when sub = 1)
- ovf  out  LANES  per-lane signed overflow of the last result
- out_valid  out  1  p/cout/ovf updated by a valid operand this cycle

## Operation
- Stage 1 (present only if REG_IN = 1): registers X-mux output, z_a/z_b-mux output, z_sel[1:0], sub, cin and in_valid when ce = 1.
- Stage 2 computes the lane results combinationally and loads p, cout, ovf.
  - Load happens only when ce = 1 and the stage-2 valid is 1.
  - Otherwise p, cout and ovf hold.
- Accumulate feedback (z_sel = 11) reads p at stage 2. Back-to-back valid accumulations therefore chain every cycle.
- Lanes are fully independent. Lane i covers bits [i·LW +: LW], with no carry between lanes. Lanes 1..LANES−1 use carry-in 0.
- Per lane, an (LW+1)-bit unsigned result is formed.
  - Low LW bits go to p.
  - Bit LW goes to cout[i]. For sub, this is the borrow (1 when Z < X + cin).
- ovf[i] = signed two's-complement overflow of the lane operation.
- Bubbles (valid = 0) never alter p, so an accumulator is preserved across idle cycles.

## Timing
- Latency from in_valid to out_valid: REG_IN + 1 cycles. Throughput: 1 operand per cycle.
- out_valid is a one-cycle pulse per accepted operand. It follows the valid pipeline and freezes with ce.
- ce = 0 freezes all stages, including in-flight valids and out_valid. Inputs sampled while ce = 0 are ignored.
- Reset values (asynchronous on rst_n low): p = 0, cout = 0, ovf = 0, out_valid = 0, all stage-1 registers = 0.
- Reset mid-operation discards in-flight operands. The first out_valid after release is REG_IN + 1 cycles after the next accepted in_valid.
- Accumulate with REG_IN = 1: the feedback value is p at the moment the operand reaches stage 2, not at capture in stage 1.

## Configuration
- POST_ADD_SAT_EN defined:
  - On ovf[i] = 1, lane i of p clamps to the signed maximum (0 followed by LW−1 ones) for positive overflow, or to the signed minimum (1 followed by LW−1 zeros) for negative overflow.
  - ovf[i] and cout[i] are still reported from the unclamped result.
  - A clamped value feeds back on accumulation.
- POST_ADD_SAT_EN undefined: lanes wrap modulo 2^LW; ovf is a flag only.

## Test plan
- Basic add, LANES = 1, REG_IN = 1: x_sel = 01, x_a = 5, z_sel = 01, z_a = 10, cin = 1, sub = 0, one in_valid.
  - Exactly 2 cycles later: p = 16, cout = 0, ovf = 0, out_valid high for 1 cycle.
- Subtract with borrow: z_a = 3, x_a = 5, cin = 0, sub = 1.
  - p = 0xFFFF_FFFF_FFFE, cout = 1, ovf = 0.
- Accumulate with bubble: after reset, z_sel = 11, x_a = 1, 4 consecutive valids, then 2 idle cycles, then 1 more valid.
  - p = 1, 2, 3, 4, holds at 4 while idle, then 5. out_valid pulses 5 times.
- SIMD lanes, LANES = 4 (LW = 12): x_a = 0x7FF_FFF_001_000, z_a = 0x001_001_001_000, cin = 0.
  - Without macro: p = 0x800_000_002_000, cout = 4'b0100, ovf = 4'b1000.
  - With POST_ADD_SAT_EN: p = 0x7FF_000_002_000.
- Control and reset:
  - ce low for 3 cycles with a valid in stage 1: p and out_valid frozen; the result appears 1 cycle after ce returns.
  - rst_n pulsed low with a valid in flight: p = 0 and out_valid is never asserted for that operand.
